// File: rtl/bullet_pkg.sv
// Shared types and screen constants for the player bullet logic.
package bullet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } bullet_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/tick_gen.sv
// Restartable clock-enable divider: one-cycle tick every TICK_DIV cycles.
// Restart zeroes the count so the next tick is TICK_DIV cycles away.
module tick_gen #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Divider count, cleared on restart and on every tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player bullet controller: launches one bullet from the plane muzzle,
// moves it upward on a divided tick, retires it on top exit or hit, then
// holds off new launches for a cooldown period.
// Build option: define PLAYER_BULLET_AUTO_FIRE_EN to fire on the held
// (synchronized) button level instead of its rising edge.
module player_bullet_ctrl
    import bullet_pkg::*;
#(
    parameter int TICK_DIV = 250000,
    parameter int STEP     = 4,
    parameter int X_OFF    = 20,
    parameter int COOLDOWN = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fire,
    input  logic [9:0] pp_x,
    input  logic [9:0] pp_y,
    input  logic       bullet_alive,
    output logic [9:0] b_x,
    output logic [9:0] b_y,
    output logic       mybullet_en
);

    localparam int COOL_W = $clog2(COOLDOWN + 1);

    // Muzzle x clamped to the right screen edge.
    function automatic coord_t sat_x(input logic [9:0] px);
        logic [10:0] sum;
        sum = {1'b0, px} + 11'(X_OFF);
        if (sum > 11'(SCREEN_W - 1)) begin
            return coord_t'(SCREEN_W - 1);
        end
        return sum[9:0];
    endfunction

    bullet_state_t     state, next_state;
    logic              fire_p1, fire_p2;
    logic              fire_req;
    logic              alive_p1;
    logic              hit;
    logic              tick;
    logic              launch, retire, move;
    logic [COOL_W-1:0] cool_cnt;
    coord_t            x_q, y_q;

    // Two-flop synchronizer for the asynchronous fire button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_p1 <= 1'b0;
            fire_p2 <= 1'b0;
        end else begin
            fire_p1 <= fire;
            fire_p2 <= fire_p1;
        end
    end

`ifdef PLAYER_BULLET_AUTO_FIRE_EN
    assign fire_req = fire_p2;
`else
    logic fire_p3;
    logic vld_p1, vld_p2;
    logic armed;

    // Edge detector; armed only once the synchronized button is seen low
    // after reset, so a press held through reset does not launch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_p3 <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            fire_p3 <= fire_p2;
            vld_p1  <= 1'b1;
            vld_p2  <= vld_p1;
            armed   <= armed | (vld_p2 & ~fire_p2);
        end
    end

    assign fire_req = fire_p2 & ~fire_p3 & armed;
`endif

    // Previous bullet_alive sample for falling-edge hit detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_p1 <= 1'b0;
        end else begin
            alive_p1 <= bullet_alive;
        end
    end

    assign hit = alive_p1 & ~bullet_alive;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (launch),
        .tick    (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes; hit takes priority over a tick.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        retire     = 1'b0;
        move       = 1'b0;
        case (state)
            IDLE: begin
                if (fire_req) begin
                    launch     = 1'b1;
                    next_state = FLY;
                end
            end
            FLY: begin
                if (hit) begin
                    retire     = 1'b1;
                    next_state = COOL;
                end else if (tick) begin
                    if (y_q < coord_t'(STEP)) begin
                        retire     = 1'b1;
                        next_state = COOL;
                    end else begin
                        move = 1'b1;
                    end
                end
            end
            COOL: begin
                if (cool_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bullet position: latched at launch, stepped upward, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (launch) begin
            x_q <= sat_x(pp_x);
            y_q <= pp_y;
        end else if (move) begin
            y_q <= y_q - coord_t'(STEP);
        end
    end

    // Cooldown counter, loaded at retire and run down while cooling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cool_cnt <= '0;
        end else if (retire) begin
            cool_cnt <= COOL_W'(COOLDOWN - 1);
        end else if (state == COOL && cool_cnt != '0) begin
            cool_cnt <= cool_cnt - 1'b1;
        end
    end

    assign b_x         = x_q;
    assign b_y         = y_q;
    assign mybullet_en = (state == FLY);

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Self-checking bench for player_bullet_ctrl with small divider values.
module tb_player_bullet_ctrl;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 4;
    localparam int X_OFF    = 20;
    localparam int COOLDOWN = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire;
    logic [9:0] pp_x, pp_y;
    logic       bullet_alive;
    logic [9:0] b_x, b_y;
    logic       mybullet_en;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t e;
    int   lat;

    player_bullet_ctrl #(
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP),
        .X_OFF    (X_OFF),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fire         (fire),
        .pp_x         (pp_x),
        .pp_y         (pp_y),
        .bullet_alive (bullet_alive),
        .b_x          (b_x),
        .b_y          (b_y),
        .mybullet_en  (mybullet_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse fire for one cycle and wait (bounded) for the bullet to appear.
    task automatic fire_and_wait(output int latency);
        fire = 1'b1;
        step();
        fire = 1'b0;
        latency = 1;
        while (mybullet_en !== 1'b1 && latency < 8) begin
            step();
            latency++;
        end
        if (mybullet_en !== 1'b1) latency = -1;
    endtask

    // Retire the current bullet with a hit, then sit out the cooldown.
    task automatic end_flight();
        bullet_alive = 1'b0;
        step();
        bullet_alive = 1'b1;
        repeat (COOLDOWN + 2) step();
    endtask

    task automatic test_reset();
        rst = 1'b0; fire = 1'b0; bullet_alive = 1'b1; pp_x = '0; pp_y = '0;
        repeat (2) step();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %0b want 0", mybullet_en); end
        n_vec++; if (b_x !== 10'd0) begin n_err++; $display("FAIL reset_bx got %0d want 0", b_x); end
        n_vec++; if (b_y !== 10'd0) begin n_err++; $display("FAIL reset_by got %0d want 0", b_y); end
        rst = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_launch();
        pp_x = 10'd100; pp_y = 10'd400;
        exp_q.push_back('{x: 10'd120, y: 10'd400});
        fire_and_wait(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL launch_latency got %0d want 3", lat); end
        e = exp_q.pop_front();
        n_vec++; if (b_x !== e.x) begin n_err++; $display("FAIL launch_bx got %0d want %0d", b_x, e.x); end
        n_vec++; if (b_y !== e.y) begin n_err++; $display("FAIL launch_by got %0d want %0d", b_y, e.y); end
        repeat (3) step();
        n_vec++; if (b_y !== 10'd400) begin n_err++; $display("FAIL pre_tick_by got %0d want 400", b_y); end
        step();
        n_vec++; if (b_y !== 10'd396) begin n_err++; $display("FAIL first_move_by got %0d want 396", b_y); end
        repeat (4) step();
        n_vec++; if (b_y !== 10'd392) begin n_err++; $display("FAIL second_move_by got %0d want 392", b_y); end
        end_flight();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL after_hit_en got %0b want 0", mybullet_en); end
    endtask

    task automatic test_top_exit();
        pp_x = 10'd100; pp_y = 10'd6;
        exp_q.push_back('{x: 10'd120, y: 10'd6});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL top_latency got %0d want 3", lat); end
        n_vec++; if (b_y !== e.y) begin n_err++; $display("FAIL top_launch_by got %0d want %0d", b_y, e.y); end
        repeat (4) step();
        n_vec++; if (b_y !== 10'd2) begin n_err++; $display("FAIL top_move_by got %0d want 2", b_y); end
        n_vec++; if (mybullet_en !== 1'b1) begin n_err++; $display("FAIL top_still_en got %0b want 1", mybullet_en); end
        repeat (4) step();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL top_retire_en got %0b want 0", mybullet_en); end
        n_vec++; if (b_y !== 10'd2) begin n_err++; $display("FAIL top_hold_by got %0d want 2", b_y); end
        repeat (4) step();
        fire = 1'b1;
        step();
        fire = 1'b0;
        repeat (10) step();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL cool_fire_dropped got %0b want 0", mybullet_en); end
        exp_q.push_back('{x: 10'd120, y: 10'd6});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL relaunch_latency got %0d want 3", lat); end
        n_vec++; if (b_y !== e.y) begin n_err++; $display("FAIL relaunch_by got %0d want %0d", b_y, e.y); end
        end_flight();
    endtask

    task automatic test_hit_on_tick();
        pp_x = 10'd100; pp_y = 10'd400;
        exp_q.push_back('{x: 10'd120, y: 10'd400});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (b_y !== e.y) begin n_err++; $display("FAIL hit_launch_by got %0d want %0d", b_y, e.y); end
        repeat (4) step();
        n_vec++; if (b_y !== 10'd396) begin n_err++; $display("FAIL hit_pre_by got %0d want 396", b_y); end
        repeat (3) step();
        bullet_alive = 1'b0;
        step();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL hit_tick_en got %0b want 0", mybullet_en); end
        n_vec++; if (b_y !== 10'd396) begin n_err++; $display("FAIL hit_tick_by got %0d want 396", b_y); end
        bullet_alive = 1'b1;
        repeat (COOLDOWN + 2) step();
    endtask

    task automatic test_alive_level();
        bullet_alive = 1'b0;
        repeat (2) step();
        pp_x = 10'd200; pp_y = 10'd100;
        exp_q.push_back('{x: 10'd220, y: 10'd100});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (b_x !== e.x) begin n_err++; $display("FAIL level_bx got %0d want %0d", b_x, e.x); end
        repeat (5) step();
        n_vec++; if (mybullet_en !== 1'b1) begin n_err++; $display("FAIL level_low_en got %0b want 1", mybullet_en); end
        n_vec++; if (b_y !== 10'd96) begin n_err++; $display("FAIL level_low_by got %0d want 96", b_y); end
        bullet_alive = 1'b1;
        step();
        end_flight();
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL level_edge_en got %0b want 0", mybullet_en); end
    endtask

    task automatic test_x_sat();
        pp_x = 10'd630; pp_y = 10'd300;
        exp_q.push_back('{x: 10'd639, y: 10'd300});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (b_x !== e.x) begin n_err++; $display("FAIL xsat_bx got %0d want %0d", b_x, e.x); end
        pp_x = 10'd0; pp_y = 10'd50;
        repeat (5) step();
        n_vec++; if (b_x !== 10'd639) begin n_err++; $display("FAIL xhold_bx got %0d want 639", b_x); end
        n_vec++; if (b_y !== 10'd296) begin n_err++; $display("FAIL xhold_by got %0d want 296", b_y); end
        end_flight();
        pp_x = 10'd619; pp_y = 10'd300;
        exp_q.push_back('{x: 10'd639, y: 10'd300});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (b_x !== e.x) begin n_err++; $display("FAIL xedge_bx got %0d want %0d", b_x, e.x); end
        end_flight();
    endtask

    task automatic test_reset_midflight();
        logic want_en;
        pp_x = 10'd50; pp_y = 10'd304;
        fire_and_wait(lat);
        repeat (4) step();
        n_vec++; if (b_y !== 10'd300) begin n_err++; $display("FAIL mid_by got %0d want 300", b_y); end
        rst = 1'b0;
        #2;
        n_vec++; if (mybullet_en !== 1'b0) begin n_err++; $display("FAIL async_en got %0b want 0", mybullet_en); end
        n_vec++; if (b_x !== 10'd0) begin n_err++; $display("FAIL async_bx got %0d want 0", b_x); end
        n_vec++; if (b_y !== 10'd0) begin n_err++; $display("FAIL async_by got %0d want 0", b_y); end
        fire = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        repeat (8) step();
`ifdef PLAYER_BULLET_AUTO_FIRE_EN
        want_en = 1'b1;
`else
        want_en = 1'b0;
`endif
        n_vec++; if (mybullet_en !== want_en) begin n_err++; $display("FAIL held_fire_en got %0b want %0b", mybullet_en, want_en); end
        fire = 1'b0;
        if (mybullet_en === 1'b1) end_flight();
        repeat (4) step();
        exp_q.push_back('{x: 10'd70, y: 10'd304});
        fire_and_wait(lat);
        e = exp_q.pop_front();
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL repress_latency got %0d want 3", lat); end
        n_vec++; if (b_x !== e.x) begin n_err++; $display("FAIL repress_bx got %0d want %0d", b_x, e.x); end
        n_vec++; if (b_y !== e.y) begin n_err++; $display("FAIL repress_by got %0d want %0d", b_y, e.y); end
        end_flight();
    endtask

    initial begin
        test_reset();
        test_launch();
        test_top_exit();
        test_hit_on_tick();
        test_alive_level();
        test_x_sat();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/player_bullet_ctrl.md
PLAYER_BULLET_CTRL -- requirements
Module: player_bullet_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 250000: clock cycles per bullet movement step.
REQ-002 Parameter STEP, default 4: pixels moved upward per step.
REQ-003 Parameter X_OFF, default 20: horizontal offset from plane origin to muzzle.
REQ-004 Parameter COOLDOWN, default 2000000: cycles after retire before the next launch is allowed.
REQ-005 Port clk  in  1  sole clock; all logic rising-edge.
REQ-006 Port rst  in  1  asynchronous, active-low reset.
REQ-007 Port fire  in  1  asynchronous fire button, active-high.
REQ-008 Port pp_x, pp_y  in  10 each  player plane origin in pixels.
REQ-009 Port bullet_alive  in  1  collision stage's bullet-still-exists flag; a 1->0 transition means hit.
REQ-010 Port b_x, b_y  out  10 each  bullet position for the collision stage.
REQ-011 Port mybullet_en  out  1  bullet exists.

Function
REQ-012 fire SHALL pass a 2-flop synchronizer, then a rising-edge detector; the edge pulse is fire_req.
REQ-013 FSM states SHALL be IDLE, FLY, COOL.
REQ-014 IDLE + fire_req SHALL go to FLY next cycle, latching b_x = min(pp_x+X_OFF, 639) and b_y = pp_y; mybullet_en = 1 from that cycle on.
REQ-015 Latency SHALL be 3 clocks from fire going high at the pin to mybullet_en = 1.
REQ-016 The step-tick counter SHALL restart at launch; the first move happens exactly TICK_DIV cycles after launch, then every TICK_DIV cycles.
REQ-017 On a tick in FLY: if b_y < STEP, retire; else b_y <= b_y - STEP (no wrap).
REQ-018 In FLY, bullet_alive registered 1 in the previous cycle and 0 now SHALL retire the bullet; a level 0 without a falling edge SHALL NOT retire it.
REQ-019 Hit and tick in the same cycle: hit wins, retire, no move.
REQ-020 Retire: mybullet_en <= 0 next cycle, go to COOL, load cooldown counter with COOLDOWN-1; b_x/b_y hold their last value.
REQ-021 COOL SHALL count down to 0, then go to IDLE.
REQ-022 fire_req in FLY or COOL SHALL be dropped, not queued; one bullet maximum.
REQ-023 pp_x/pp_y changes during FLY SHALL NOT affect b_x; b_x is constant in flight.

Reset
REQ-024 rst low SHALL immediately force IDLE, b_x = 0, b_y = 0, mybullet_en = 0, and clear all counters and synchronizer flops, including mid-flight and mid-cooldown.
REQ-025 Operation resumes on the first clk edge after rst deasserts; a fire held through reset SHALL NOT launch until released and pressed again, except under AUTO_FIRE_EN.

Configuration
REQ-026 Macro PLAYER_BULLET_AUTO_FIRE_EN defined: fire_req is the synchronized level, so holding fire relaunches on the first IDLE cycle after COOL.
REQ-027 Macro undefined: edge-only firing as in REQ-012; holding fire yields exactly one bullet.

Structure
REQ-028 Shared package bullet_pkg SHALL hold the state enum (IDLE/FLY/COOL), SCREEN_W = 640, SCREEN_H = 480, and the 10-bit coordinate typedef.
REQ-029 One sub-module, tick_gen (restartable clock-enable divider, parameter TICK_DIV), SHALL produce the step tick.

Verification (bench uses TICK_DIV=4, STEP=4, X_OFF=20, COOLDOWN=8)
REQ-030 Launch: pp_x = 100, pp_y = 400, pulse fire -> after 3 clocks mybullet_en = 1, b_x = 120, b_y = 400; after 4 more clocks b_y = 396.
REQ-031 Top exit: launch at pp_y = 6 -> b_y = 6, then 2, then mybullet_en = 0; fire 4 cycles later is ignored; after 8 cooldown cycles a fire launches again.
REQ-032 Hit: in FLY, drive bullet_alive 1->0 on the same cycle as a tick -> mybullet_en = 0 next cycle, b_y unchanged.
REQ-033 X saturation and hold: pp_x = 630 -> b_x = 639; then move pp_x to 0 in flight -> b_x stays 639.
REQ-034 Reset mid-flight: assert rst at b_y = 300 -> outputs 0 immediately without a clock edge; hold fire through reset release -> no launch (macro undefined) or launch (macro defined).
